// File: rtl/neuron_alu_sequencer.sv
// Neuron sequencer: drives one shared ALU through multiply, accumulate and
// ReLU steps for each (x,w) pair, then reports ReLU(acc) and the fire flag.
module neuron_alu_sequencer #(
   parameter int nBits = 32,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [CNT_W-1:0] num_inputs,
   output logic             in_req,
   input  logic             in_valid,
   input  logic [nBits-1:0] x_in,
   input  logic [nBits-1:0] w_in,
   output logic [2:0]       ALU1Control,
   output logic [nBits-1:0] SrcA,
   output logic [nBits-1:0] SrcB,
   input  logic [nBits-1:0] ALUResult,
   output logic             busy,
   output logic             done,
   output logic [nBits-1:0] neuron_out,
   output logic             fire
);

   // state | meaning
   // IDLE  | waiting for start
   // FETCH | requesting next (x,w) pair
   // MUL   | ALU multiplies x_reg*w_reg into prod
   // ACC   | ALU adds prod into acc, one pair consumed
   // ACT   | ALU evaluates acc >= 0, result registered
   // DONE  | one-cycle done pulse
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_MUL   = 3'd2,
      S_ACC   = 3'd3,
      S_ACT   = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_MUL  = 3'b001;
   localparam logic [2:0] OP_SNN  = 3'b010;
   localparam logic [2:0] OP_PASS = 3'b111;

   state_t           state, state_nxt;
   logic [nBits-1:0] acc, prod, x_reg, w_reg;
   logic [CNT_W-1:0] count;

   // state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= state_nxt;
   end

   // next-state decode
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = (num_inputs != '0) ? S_FETCH : S_ACT;
         S_FETCH: if (in_valid) state_nxt = S_MUL;
         S_MUL:   state_nxt = S_ACC;
         S_ACC:   state_nxt = (count == CNT_W'(1)) ? S_ACT : S_FETCH;
         S_ACT:   state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // ALU drive and handshake outputs, decoded from state and registers only
   always_comb begin
      ALU1Control = OP_PASS;
      SrcA        = acc;
      SrcB        = '0;
      in_req      = 1'b0;
      busy        = (state != S_IDLE);
      done        = (state == S_DONE);
      case (state)
         S_FETCH: in_req = 1'b1;
         S_MUL: begin
            ALU1Control = OP_MUL;
            SrcA        = x_reg;
            SrcB        = w_reg;
         end
         S_ACC: begin
            ALU1Control = OP_ADD;
            SrcB        = prod;
         end
         S_ACT:   ALU1Control = OP_SNN;
         default: ;
      endcase
   end

   // datapath registers; each state captures the ALU result it asked for
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc        <= '0;
         prod       <= '0;
         x_reg      <= '0;
         w_reg      <= '0;
         count      <= '0;
         neuron_out <= '0;
         fire       <= 1'b0;
      end else begin
         case (state)
            S_IDLE: if (start) begin
               acc   <= '0;
               count <= num_inputs;
            end
            S_FETCH: if (in_valid) begin
               x_reg <= x_in;
               w_reg <= w_in;
            end
            S_MUL: prod <= ALUResult;
            S_ACC: begin
               acc   <= ALUResult;
               count <= count - CNT_W'(1);
            end
            S_ACT: begin
               fire       <= ALUResult[0];
               neuron_out <= ALUResult[0] ? acc : '0;
            end
            default: ;
         endcase
      end
   end

endmodule
